multi_player_motion_ctrl: RTL and testbench

//   Next-generation player movement engine for 1..4 players sharing one map-RAM read port.
//   On each movement tick it walks the players in order, probes the map tiles under the sprite's

---
 rtl/multi_player_motion_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multi_player_motion_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_player_motion_ctrl.sv
// Multi-player movement engine: per-tick leading-edge map probes, full-step or flush-snap commit.
// Optional feature macro: PMC_SPEED_BOOST_EN (adds per-player boost input, doubling the step).
module multi_player_motion_ctrl #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int TILE_PX       = 64,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 64,
  parameter int STEP_SIZE     = 4,
  parameter int HUD_SIDE_PX   = 32,
  parameter int HUD_TOP_PX    = 96,
  localparam int AW           = $clog2(NUM_ROW * NUM_COL)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic [4*NUM_PLAYERS-1:0]   move_dir,
`ifdef PMC_SPEED_BOOST_EN
  input  logic [NUM_PLAYERS-1:0]     boost,
`endif
  output logic                       map_rd_en,
  output logic [AW-1:0]              map_addr,
  input  logic [MAP_MEM_WIDTH-1:0]   map_mem_in,
  output logic [11*NUM_PLAYERS-1:0]  player_x,
  output logic [10*NUM_PLAYERS-1:0]  player_y,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int TS = $clog2(TILE_PX);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_COMMIT} state_t;

  state_t          r_state, w_state_nx;
  logic [PW-1:0]   r_p;
  logic [3:0]      r_dir [NUM_PLAYERS];
  logic [11:0]     r_x   [NUM_PLAYERS];
  logic [11:0]     r_y   [NUM_PLAYERS];
  logic            r_blk_a, r_blk_b, r_done;
`ifdef PMC_SPEED_BOOST_EN
  logic [NUM_PLAYERS-1:0] r_boost;
`endif

  logic [11:0] w_cx, w_cy, w_step, w_lead, w_lidx;
  logic [11:0] w_row_a, w_col_a, w_row_b, w_col_b, w_snap_lo, w_snap_hi, w_nx, w_ny;
  logic [3:0]  w_dir;
  logic        w_up, w_dn, w_lf, w_rt, w_valid, w_vert, w_neg, w_oob_a, w_oob_b, w_last;
  logic [AW-1:0] w_addr_a, w_addr_b;

  function automatic logic [11:0] start_x(input int unsigned p);
    return (p == 1 || p == 2) ? 12'((NUM_COL - 2) * TILE_PX) : 12'(TILE_PX);
  endfunction

  function automatic logic [11:0] start_y(input int unsigned p);
    return (p == 1 || p == 3) ? 12'((NUM_ROW - 2) * TILE_PX) : 12'(TILE_PX);
  endfunction

  assign w_last = (r_p == PW'(NUM_PLAYERS - 1));

  // Probe geometry and commit target for the player currently being served.
  always_comb begin
    w_cx   = r_x[r_p];
    w_cy   = r_y[r_p];
    w_dir  = r_dir[r_p];
    w_step = 12'(STEP_SIZE);
`ifdef PMC_SPEED_BOOST_EN
    if (r_boost[r_p]) w_step = 12'(2 * STEP_SIZE);
`endif
    w_up    = (w_dir == 4'b1000);
    w_dn    = (w_dir == 4'b0100);
    w_lf    = (w_dir == 4'b0010);
    w_rt    = (w_dir == 4'b0001);
    w_valid = w_up | w_dn | w_lf | w_rt;
    w_vert  = w_up | w_dn;
    w_lead  = w_up ? (w_cy - w_step) :
              w_dn ? (w_cy + 12'(SPRITE_H - 1) + w_step) :
              w_lf ? (w_cx - w_step) :
                     (w_cx + 12'(SPRITE_W - 1) + w_step);
    w_neg   = (w_up && (w_cy < w_step)) || (w_lf && (w_cx < w_step));
    w_lidx  = w_lead >> TS;
    if (w_vert) begin
      w_row_a = w_lidx;
      w_row_b = w_lidx;
      w_col_a = w_cx >> TS;
      w_col_b = (w_cx + 12'(SPRITE_W - 1)) >> TS;
    end else begin
      w_col_a = w_lidx;
      w_col_b = w_lidx;
      w_row_a = w_cy >> TS;
      w_row_b = (w_cy + 12'(SPRITE_H - 1)) >> TS;
    end
    w_oob_a  = w_neg || (w_row_a >= 12'(NUM_ROW)) || (w_col_a >= 12'(NUM_COL));
    w_oob_b  = w_neg || (w_row_b >= 12'(NUM_ROW)) || (w_col_b >= 12'(NUM_COL));
    w_addr_a = AW'(w_row_a * 12'(NUM_COL) + w_col_a);
    w_addr_b = AW'(w_row_b * 12'(NUM_COL) + w_col_b);
    w_snap_lo = (w_lidx + 12'd1) << TS;
    w_snap_hi = (w_lidx << TS) - (w_vert ? 12'(SPRITE_H) : 12'(SPRITE_W));
    w_nx = w_cx;
    w_ny = w_cy;
    if (w_valid) begin
      if (!r_blk_a && !r_blk_b) begin
        if (w_up) w_ny = w_cy - w_step;
        if (w_dn) w_ny = w_cy + w_step;
        if (w_lf) w_nx = w_cx - w_step;
        if (w_rt) w_nx = w_cx + w_step;
      end else begin
        // A snap that would move against the request leaves the position untouched.
        if (w_up && (w_snap_lo <= w_cy)) w_ny = w_snap_lo;
        if (w_dn && (w_snap_hi >= w_cy)) w_ny = w_snap_hi;
        if (w_lf && (w_snap_lo <= w_cx)) w_nx = w_snap_lo;
        if (w_rt && (w_snap_hi >= w_cx)) w_nx = w_snap_hi;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    map_rd_en  = 1'b0;
    map_addr   = '0;
    case (r_state)
      S_IDLE:   if (tick) w_state_nx = S_RD_A;
      S_RD_A: begin
        map_rd_en  = w_valid && !w_oob_a;
        map_addr   = w_addr_a;
        w_state_nx = S_RD_B;
      end
      S_RD_B: begin
        map_rd_en  = w_valid && !w_oob_b;
        map_addr   = w_addr_b;
        w_state_nx = S_CAP_B;
      end
      S_CAP_B:  w_state_nx = S_COMMIT;
      S_COMMIT: w_state_nx = w_last ? S_IDLE : S_RD_A;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_blk_a <= 1'b0;
      r_blk_b <= 1'b0;
      r_done  <= 1'b0;
`ifdef PMC_SPEED_BOOST_EN
      r_boost <= '0;
`endif
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        r_x[i]   <= start_x(i);
        r_y[i]   <= start_y(i);
        r_dir[i] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (tick) begin
          r_p <= '0;
          for (int unsigned i = 0; i < NUM_PLAYERS; i++) r_dir[i] <= move_dir[4*i +: 4];
`ifdef PMC_SPEED_BOOST_EN
          r_boost <= boost;
`endif
        end
        S_RD_B:  r_blk_a <= w_oob_a || (map_mem_in != '0);
        S_CAP_B: r_blk_b <= w_oob_b || (map_mem_in != '0);
        S_COMMIT: begin
          r_x[r_p] <= w_nx;
          r_y[r_p] <= w_ny;
          if (w_last) r_done <= 1'b1;
          else        r_p    <= r_p + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    player_x = '0;
    player_y = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      player_x[11*i +: 11] = 11'(r_x[i] + 12'(HUD_SIDE_PX));
      player_y[10*i +: 10] = 10'(r_y[i] + 12'(HUD_TOP_PX));
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_multi_player_motion_ctrl.sv
// Directed bench for multi_player_motion_ctrl (default parameters, two players) with a walled-map model.
module tb_multi_player_motion_ctrl;

  logic        clk, rst_n, tick;
  logic [7:0]  move_dir;
  logic        map_rd_en;
  logic [7:0]  map_addr;
  logic [1:0]  map_mem_in;
  logic [21:0] player_x;
  logic [19:0] player_y;
  logic        busy, done;
`ifdef PMC_SPEED_BOOST_EN
  logic [1:0]  boost;
`endif

  int checks = 0;
  int errors = 0;
  bit wall_col1 = 0, wall_col2 = 0, border_on = 1;

  multi_player_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .move_dir   (move_dir),
`ifdef PMC_SPEED_BOOST_EN
    .boost      (boost),
`endif
    .map_rd_en  (map_rd_en),
    .map_addr   (map_addr),
    .map_mem_in (map_mem_in),
    .player_x   (player_x),
    .player_y   (player_y),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_wall(input int addr);
    int r, c;
    r = addr / 19;
    c = addr % 19;
    return (border_on && (r == 0 || r == 10 || c == 0 || c == 18)) ||
           (wall_col1 && c == 1) || (wall_col2 && c == 2);
  endfunction

  // Read data valid one cycle after the strobe; garbage otherwise.
  always @(posedge clk)
    map_mem_in <= map_rd_en ? (is_wall(int'(map_addr)) ? 2'b01 : 2'b00) : 2'b10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input bit extra, output int lat, output logic [7:0] pat,
                         output logic [7:0] addr0);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    lat   = 1;
    pat   = '0;
    pat[0] = map_rd_en;
    addr0 = map_addr;
    while (!done && lat < 40) begin
      if (extra && lat == 3) tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      lat++;
      if (lat <= 8) pat[lat-1] = map_rd_en;
    end
  endtask

  initial begin
    int lat, dcnt, bcnt;
    logic [7:0] pat, a0;
    rst_n = 1'b1; tick = 1'b0; move_dir = '0;
`ifdef PMC_SPEED_BOOST_EN
    boost = '0;
`endif
    // Asynchronous reset asserted mid-cycle
    #12 rst_n = 1'b0;
    #1;
    chk("rst_p0x", 32'(player_x[10:0]), 96);
    chk("rst_p0y", 32'(player_y[9:0]), 160);
    chk("rst_p1x", 32'(player_x[21:11]), 1120);
    chk("rst_p1y", 32'(player_y[19:10]), 672);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rden", 32'(map_rd_en), 0);
    chk("rst_addr", 32'(map_addr), 0);
    @(negedge clk) rst_n = 1'b1;

    // Free step right
    move_dir = 8'h01;
    run_seq(0, lat, pat, a0);
    chk("right_lat", 32'(lat), 9);
    chk("right_done_busy", 32'(busy), 0);
    chk("right_pat", 32'(pat), 32'h03);
    chk("right_addr", 32'(a0), 20);
    chk("right_p0x", 32'(player_x[10:0]), 100);
    chk("right_p1x", 32'(player_x[21:11]), 1120);
    chk("right_p1y", 32'(player_y[19:10]), 672);
    @(posedge clk) #1;
    chk("done_pulse", 32'(done), 0);

    // Walk toward walled column 2
    wall_col2 = 1;
    for (int i = 0; i < 6; i++) run_seq(0, lat, pat, a0);
    chk("walk_p0x", 32'(player_x[10:0]), 124);
    run_seq(0, lat, pat, a0);
    chk("flush_p0x", 32'(player_x[10:0]), 128);
    run_seq(0, lat, pat, a0);
    chk("blocked_p0x", 32'(player_x[10:0]), 128);
    chk("blocked_addr", 32'(a0), 21);
    chk("blocked_pat", 32'(pat), 32'h03);

    // p0 UP into row 0, p1 DOWN into row 10
    move_dir = 8'h48;
    run_seq(0, lat, pat, a0);
    chk("up_p0y", 32'(player_y[9:0]), 160);
    chk("dn_p1y", 32'(player_y[19:10]), 672);
    chk("updn_pat", 32'(pat), 32'h33);
    chk("updn_p0x", 32'(player_x[10:0]), 128);

    // Non-one-hot direction plus a tick while busy
    move_dir = 8'h0A;
    run_seq(1, lat, pat, a0);
    chk("bad_lat", 32'(lat), 9);
    chk("bad_pat", 32'(pat), 0);
    chk("bad_p0x", 32'(player_x[10:0]), 128);
    chk("bad_p0y", 32'(player_y[9:0]), 160);
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk) #1;
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("busy_tick_done", 32'(dcnt), 0);
    chk("busy_tick_busy", 32'(bcnt), 0);

    // Reset during RD_B
    wall_col2 = 0;
    move_dir = 8'h01;
    @(negedge clk) tick = 1'b1;
    @(posedge clk) #1 tick = 1'b0;
    @(posedge clk) #2 rst_n = 1'b0;
    #1;
    chk("rdb_rst_busy", 32'(busy), 0);
    chk("rdb_rst_rden", 32'(map_rd_en), 0);
    chk("rdb_rst_p0x", 32'(player_x[10:0]), 96);
    @(negedge clk) rst_n = 1'b1;
    run_seq(0, lat, pat, a0);
    chk("post_rst_lat", 32'(lat), 9);
    chk("post_rst_p0x", 32'(player_x[10:0]), 100);

    // Snaps that would move backwards are suppressed
    wall_col1 = 1;
    run_seq(0, lat, pat, a0);
    chk("hold_right_p0x", 32'(player_x[10:0]), 100);
    move_dir = 8'h02;
    run_seq(0, lat, pat, a0);
    chk("hold_left_p0x", 32'(player_x[10:0]), 100);

    // Open map: walk p0 to y=0, then probe goes off-map
    wall_col1 = 0;
    border_on = 0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    move_dir = 8'h08;
    for (int i = 0; i < 16; i++) run_seq(0, lat, pat, a0);
    chk("top_p0y", 32'(player_y[9:0]), 96);
    run_seq(0, lat, pat, a0);
    chk("oob_pat", 32'(pat), 0);
    chk("oob_p0y", 32'(player_y[9:0]), 96);

`ifdef PMC_SPEED_BOOST_EN
    border_on = 1;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    boost = 2'b01;
    move_dir = 8'h01;
    run_seq(0, lat, pat, a0);
    chk("boost_p0x", 32'(player_x[10:0]), 104);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
